noc_port_arbiter: RTL and testbench
===================================

// Module: noc_port_arbiter
// PURPOSE
//  Packet-aware round-robin arbiter. It shares one NoC output link between NUM_IN input FIFOs.
//  It reads flits from the head of each source FIFO (show-ahead head, rd_en pops) and holds
//  the grant from the first flit of a packet until its tail flit. It drives the flit into a
//  registered output stage with a valid/ready handshake. It sits between a router's input
//  FIFOs and one output port.
// PARAMETERS
//  NUM_IN  4   number of requesting FIFOs; must be >= 2
//  WIDTH   32  flit data width
// PORTS
//  clk          in   1              clock, all logic on posedge
//  rst          in   1              synchronous, active-high reset
//  src_data     in   NUM_IN*WIDTH   head flit of FIFO i at [i*WIDTH +: WIDTH]
//  src_tail     in   NUM_IN         head flit of FIFO i is a packet tail
//  src_empty    in   NUM_IN         FIFO i empty
//  src_rd_en    out  NUM_IN         pop FIFO i; at most one bit set; never set while src_empty[i]
//  out_data     out  WIDTH          registered flit
//  out_tail     out  1              registered tail flag
//  out_valid    out  1              out_data/out_tail valid
//  out_ready    in   1              downstream accepts when out_valid && out_ready
//  grant_id     out  $clog2(NUM_IN) current or last owner
//  locked       out  1              a packet is in progress (state LOCKED)
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_tail=0, grant_id=0, locked=0; state=IDLE;
//    rr_ptr=0; src_rd_en is combinationally 0 while rst=1.
//  - load_ok = !out_valid || out_ready. A flit can enter the output register only when load_ok=1.
//  - Pop and load happen in the same cycle. src_rd_en[g]=1 loads src_data[g]/src_tail[g] into
//    the output register at the next edge. Head-to-out_valid latency is 1 cycle.
//    Throughput is 1 flit/cycle.
//  - If out_valid && out_ready and nothing is loaded, out_valid clears at the next edge.
//    While out_valid && !out_ready, out_data/out_tail hold stable.
//  - FSM IDLE:
//    - Arbitrate only when load_ok and at least one FIFO is non-empty (req = ~src_empty).
//    - The winner is the first requester at or after rr_ptr, in modular order. Pop it and set
//      grant_id to the winner.
//    - If the popped flit is a tail (single-flit packet): stay IDLE and set rr_ptr = winner+1
//      (mod NUM_IN).
//    - Otherwise: go to LOCKED with owner = winner.
//    - If !load_ok: no decision is made and no state changes.
//  - FSM LOCKED:
//    - Only the owner may pop, when !src_empty[owner] && load_ok.
//    - If the owner is empty mid-packet: bubble. Output goes idle, other requesters are
//      ignored, and the FSM stays LOCKED.
//    - When a tail is popped: go to IDLE and set rr_ptr = owner+1 (mod NUM_IN). A new
//      arbitration can pop on the next cycle, so there is no dead cycle when out_ready=1.
//  - rr_ptr advances only on packet completion. It wraps NUM_IN-1 -> 0. Width is
//    $clog2(NUM_IN), with an explicit wrap for non-power-of-2 NUM_IN.
//  - Reset mid-packet drops the in-flight flit and any remaining packet state. The bench owns
//    flushing the source FIFOs.
//  - A flit is never duplicated or dropped between pop and output.
// STRUCTURE
//  - Shared package noc_pkg holds:
//    - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
//    - localparam NOC_FLIT_W = 32.
//  - Sub-module noc_rr_pick: combinational, parameter N. Inputs req[N] and ptr. Outputs
//    gnt_vld and a gnt_idx binary index. Implemented as a double-width masked priority search.
//  - Top level holds the FSM, rr_ptr, the owner register and the output register.
// TESTING
//  1. Ports 0-3 each hold 2 single-flit packets, out_ready=1
//     -> output order p0,p1,p2,p3,p0,p1,p2,p3; one flit/cycle; first out_valid 1 cycle after
//     the first non-empty.
//  2. Port1 holds a 3-flit packet (tail on flit 3) and port2 holds 1 flit from the same cycle
//     -> outputs p1,p1,p1,p2; locked=1 during p1; rr_ptr=2 after the p1 tail.
//  3. out_valid=1, out_ready held 0 for 5 cycles
//     -> out_data stable; src_rd_en=0 all 5 cycles; flow resumes the cycle out_ready=1.
//  4. Port0 header popped, then port0 empty 3 cycles, port3 non-empty
//     -> 3 idle output cycles; no port3 pop; locked=1; port0 tail then port3 follows.
//  5. rst pulsed for 1 cycle mid-packet on port2
//     -> next cycle out_valid=0, locked=0, grant_id=0; next arbitration favours port0.
//  6. Port0 continuously backlogged with 2-flit packets, ports1-3 each hold one packet
//     -> each of ports 1-3 is served before port0's second packet.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types and widths used by the port arbiter and its helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package noc_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  localparam int NOC_FLIT_W = 32;

endpackage

// File: rtl/noc_rr_pick.sv
// Round-robin pick: first requester at or after ptr, searching in modular order.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module noc_rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_vld,
  output logic [PW-1:0] gnt_idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  // Duplicate the request vector, hide requesters below ptr in the lower copy,
  // then take the lowest set bit; the upper copy supplies the wrapped-around part.
  always_comb begin
    dbl     = {req, req};
    masked  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < 2*N; k++) begin
      masked[k] = dbl[k] && (k >= int'(ptr));
    end
    for (int k = 0; k < 2*N; k++) begin
      if (!found && masked[k]) begin
        found   = 1'b1;
        gnt_idx = (k >= N) ? PW'(k - N) : PW'(k);
      end
    end
  end

  assign gnt_vld = |req;

endmodule

// File: rtl/noc_port_arbiter.sv
// Packet-aware round-robin arbiter sharing one output link among NUM_IN show-ahead FIFOs.
// Latency: 1 cycle from FIFO head to out_valid; 1 flit/cycle sustained.
// Backpressure: no pop while out_valid && !out_ready; output register holds stable.
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int WIDTH  = NOC_FLIT_W,
  localparam int IW     = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] src_data,
  input  logic [NUM_IN-1:0]       src_tail,
  input  logic [NUM_IN-1:0]       src_empty,
  output logic [NUM_IN-1:0]       src_rd_en,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_tail,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           grant_id,
  output logic                    locked
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic              load_ok;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic              pop;
  logic [IW-1:0]     pop_idx;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_tail;

  // Explicit wrap so non-power-of-2 port counts never point past the last port.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_IN - 1)) ? '0 : v + 1'b1;
  endfunction

  assign load_ok = !out_valid || out_ready;
  assign locked  = (state == ARB_LOCKED);

  noc_rr_pick #(.N(NUM_IN)) u_pick (
    .req     (~src_empty),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // FSM next state and pop decision; a pop always coincides with an output load.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    pop_idx   = owner;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          if (load_ok && gnt_vld) begin
            pop     = 1'b1;
            pop_idx = gnt_idx;
            if (!src_tail[gnt_idx]) state_nxt = ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // Owner running dry mid-packet leaves a bubble; nobody else may cut in.
          if (load_ok && !src_empty[owner]) begin
            pop     = 1'b1;
            pop_idx = owner;
            if (src_tail[owner]) state_nxt = ARB_IDLE;
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  // One-hot pop strobe and head-flit mux for the selected port.
  always_comb begin
    src_rd_en = '0;
    sel_data  = '0;
    sel_tail  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pop_idx == IW'(i)) begin
        src_rd_en[i] = pop;
        sel_data     = src_data[i*WIDTH +: WIDTH];
        sel_tail     = src_tail[i];
      end
    end
  end

  // State register, round-robin pointer, owner and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tail  <= 1'b0;
      grant_id  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_tail  <= sel_tail;
        grant_id  <= pop_idx;
        if (state == ARB_IDLE) owner <= pop_idx;
        // Pointer moves only when a packet completes.
        if (sel_tail) rr_ptr <= wrap_inc(pop_idx);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter: FIFO models, a cycle-level reference arbiter, random traffic.
// Latency: expects output one cycle after each pop predicted by the reference.
// Backpressure: drives out_ready both held and randomized.
module tb_noc_port_arbiter;
  import noc_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_tail;
  logic [N-1:0]   src_empty;
  logic [N-1:0]   src_rd_en;
  logic [W-1:0]   out_data;
  logic           out_tail;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     grant_id;
  logic           locked;

  always #5 clk = ~clk;

  noc_port_arbiter #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .src_tail  (src_tail),
    .src_empty (src_empty),
    .src_rd_en (src_rd_en),
    .out_data  (out_data),
    .out_tail  (out_tail),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  typedef struct packed {logic tail; logic [W-1:0] data;} flit_t;
  typedef struct packed {logic [1:0] port; logic tail; logic [W-1:0] data;} exp_t;

  flit_t      fq[N][$];
  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [N-1:0] snap = '0;

  // reference arbiter state
  bit mvalid  = 1'b0;
  bit mlocked = 1'b0;
  int mptr    = 0;
  int mowner  = 0;
  int mgrant  = 0;
  bit armed   = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // Source FIFOs: pop what the DUT strobed last cycle, then present the new heads.
  initial begin
    src_empty = '1;
    src_data  = '0;
    src_tail  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (snap[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      #1;
      for (int i = 0; i < N; i++) begin
        src_empty[i] = (fq[i].size() == 0);
        if (fq[i].size() > 0) begin
          src_data[i*W +: W] = fq[i][0].data;
          src_tail[i]        = fq[i][0].tail;
        end else begin
          src_data[i*W +: W] = '0;
          src_tail[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor and reference model, evaluated mid-cycle.
  initial begin
    int           w;
    bit           lok;
    flit_t        f;
    exp_t         e;
    logic [N-1:0] exp_rd;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("out_valid", W'(out_valid), W'(mvalid));
        chk("locked", W'(locked), W'(mlocked));
        chk("grant_id", W'(grant_id), W'(mgrant));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_flit");
          else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_tail", W'(out_tail), W'(e.tail));
            chk("out_port", W'(grant_id), W'(e.port));
          end
        end
      end
      exp_rd = '0;
      if (rst) begin
        mvalid = 0; mlocked = 0; mptr = 0; mowner = 0; mgrant = 0;
        exp_q.delete();
        armed = 1'b1;
      end else begin
        lok = !mvalid || out_ready;
        w = -1;
        if (lok) begin
          if (!mlocked) begin
            for (int k = 0; k < N; k++)
              if (w < 0 && fq[(mptr + k) % N].size() > 0) w = (mptr + k) % N;
          end else if (fq[mowner].size() > 0) begin
            w = mowner;
          end
        end
        if (w >= 0) begin
          f = fq[w][0];
          e.port = 2'(w); e.tail = f.tail; e.data = f.data;
          exp_q.push_back(e);
          exp_rd[w] = 1'b1;
          mgrant = w;
          mvalid = 1'b1;
          if (!mlocked) begin
            if (f.tail) mptr = (w + 1) % N;
            else begin mlocked = 1'b1; mowner = w; end
          end else if (f.tail) begin
            mlocked = 1'b0;
            mptr = (mowner + 1) % N;
          end
        end else if (out_ready) begin
          mvalid = 1'b0;
        end
      end
      chk("src_rd_en", W'(src_rd_en), W'(exp_rd));
      snap = src_rd_en;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_flit(input int p, input bit tail);
    flit_t f;
    f.tail = tail;
    f.data = $urandom();
    fq[p].push_back(f);
  endtask

  task automatic push_pkt(input int p, input int len);
    for (int k = 0; k < len; k++) push_flit(p, k == len - 1);
  endtask

  function automatic bit busy();
    bit b;
    b = out_valid || (exp_q.size() != 0);
    for (int i = 0; i < N; i++) if (fq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int maxc);
    int c = 0;
    cyc(2);
    while (busy() && c < maxc) begin cyc(); c++; end
    if (busy()) fail_now(name);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    out_ready = 1'b1;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_tail", W'(out_tail), '0);
    chk("reset_grant", W'(grant_id), '0);

    // single-flit packets on every port: strict rotation
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) push_pkt(p, 1);
    cyc();
    drain("drain_rotation", 100);

    // 3-flit packet on port1 racing a single on port2, then 0 vs 3 from ptr=3
    push_pkt(1, 3);
    push_pkt(2, 1);
    drain("drain_locked", 100);
    push_pkt(0, 1);
    push_pkt(3, 1);
    drain("drain_ptr_wrap", 100);

    // output stall for 5 cycles
    for (int k = 0; k < 4; k++) push_pkt(0, 1);
    c = 0;
    while (!out_valid && c < 20) begin cyc(); c++; end
    if (!out_valid) fail_now("stall_wait_valid");
    out_ready = 1'b0;
    cyc(5);
    out_ready = 1'b1;
    drain("drain_stall", 100);

    // owner bubble: port0 header, empty 3 cycles, port3 waiting
    push_flit(0, 1'b0);
    cyc(2);
    push_pkt(3, 1);
    cyc(3);
    push_flit(0, 1'b1);
    drain("drain_bubble", 100);

    // reset in the middle of a port2 packet
    push_pkt(2, 4);
    push_pkt(1, 1);
    cyc(2);
    rst = 1'b1;
    cyc();
    for (int i = 0; i < N; i++) fq[i].delete();
    rst = 1'b0;
    push_pkt(3, 1);
    push_pkt(1, 1);
    push_pkt(0, 1);
    drain("drain_after_reset", 100);

    // port0 backlogged with 2-flit packets competing with ports 1-3
    for (int k = 0; k < 3; k++) push_pkt(0, 2);
    for (int p = 1; p < N; p++) push_pkt(p, 2);
    drain("drain_fairness", 200);

    // random traffic with random backpressure
    for (int t = 0; t < 600; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, N - 1);
        if (fq[c].size() < 12) push_pkt(c, $urandom_range(1, 4));
      end
      cyc();
    end
    out_ready = 1'b1;
    drain("drain_random", 2000);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
